decode_stage: RTL and testbench

Registered, parametrised LEGv8 instruction-decode pipeline stage. It sits between fetch and register-read/execute. It accepts one instruction per cycle over a valid/ready handshake and decodes it into register indices, an XLEN-bit immediate and the standard control bundle. Beyond the single-instruction combinational decoder it adds CBNZ, BL link write, MOVK, illegal-opcode flagging, flush, backpressure and optional load-use stall insertion.

---
 rtl/decode_pkg.sv | 38 +++
 rtl/decode_comb.sv | 101 ++++++++++
 rtl/decode_stage.sv | 137 +++++++++++++
 tb/tb_decode_stage.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/decode_pkg.sv
// rtl/decode_pkg.sv - LEGv8 decode opcodes, ALU-op encodings, register aliases and control bundle.
package decode_pkg;

    localparam logic [10:0] OP_ADD  = 11'b10001011000;
    localparam logic [10:0] OP_SUB  = 11'b11001011000;
    localparam logic [10:0] OP_AND  = 11'b10001010000;
    localparam logic [10:0] OP_ORR  = 11'b10101010000;
    localparam logic [10:0] OP_LDUR = 11'b11111000010;
    localparam logic [10:0] OP_STUR = 11'b11111000000;
    localparam logic [7:0]  OP_CBZ  = 8'b10110100;
    localparam logic [7:0]  OP_CBNZ = 8'b10110101;
    localparam logic [5:0]  OP_B    = 6'b000101;
    localparam logic [5:0]  OP_BL   = 6'b100101;
    localparam logic [9:0]  OP_ADDI = 10'b1001000100;
    localparam logic [8:0]  OP_MOVK = 9'b111100101;

    localparam logic [1:0] ALU_OP_ADD   = 2'b00;
    localparam logic [1:0] ALU_OP_CBZ   = 2'b01;
    localparam logic [1:0] ALU_OP_RTYPE = 2'b10;
    localparam logic [1:0] ALU_OP_MOV   = 2'b11;

    localparam logic [4:0] XZR      = 5'd31;
    localparam logic [4:0] LINK_REG = 5'd30;

    typedef struct packed {
        logic       reg2loc;
        logic       uncondbranch;
        logic       branch;
        logic       branch_nz;
        logic       mem_read;
        logic       mem_to_reg;
        logic       mem_write;
        logic       alu_src;
        logic       reg_write;
        logic [1:0] alu_op;
    } ctrl_t;

endpackage

// File: rtl/decode_comb.sv
// rtl/decode_comb.sv - combinational LEGv8 field, control and immediate decode.
module decode_comb
    import decode_pkg::*;
#(
    parameter int XLEN         = 64,
    parameter int SHIFT_BRANCH = 0
) (
    input  logic [31:0]     instr,
    output ctrl_t           ctrl,
    output logic [4:0]      register1,
    output logic [4:0]      register2,
    output logic [4:0]      write_register,
    output logic [XLEN-1:0] immediate,
    output logic            illegal,
    output logic            reads_r1,
    output logic            reads_r2
);

    localparam int unsigned BR_SHIFT = (SHIFT_BRANCH != 0) ? 2 : 0;

    logic [XLEN-1:0] imm_d9;
    logic [XLEN-1:0] imm_i12;
    logic [XLEN-1:0] imm_cb;
    logic [XLEN-1:0] imm_b;
    logic [XLEN-1:0] imm_mov;
    logic [63:0]     mov_wide;
    logic            uncond;

    assign imm_d9   = {{(XLEN-9){instr[20]}}, instr[20:12]};
    assign imm_i12  = {{(XLEN-12){instr[21]}}, instr[21:10]};
    assign imm_cb   = {{(XLEN-19){instr[23]}}, instr[23:5]} << BR_SHIFT;
    assign imm_b    = {{(XLEN-26){instr[25]}}, instr[25:0]} << BR_SHIFT;
    // MOVK halfword placement is done at 64 bits and then truncated to XLEN.
    assign mov_wide = {48'b0, instr[20:5]} << {instr[22:21], 4'b0000};
    assign imm_mov  = mov_wide[XLEN-1:0];

    always_comb begin
        ctrl           = '0;
        immediate      = '0;
        illegal        = 1'b0;
        reads_r1       = 1'b0;
        reads_r2       = 1'b0;
        uncond         = 1'b0;
        write_register = instr[4:0];
        if (instr[31:21] == OP_ADD || instr[31:21] == OP_SUB ||
            instr[31:21] == OP_AND || instr[31:21] == OP_ORR) begin
            ctrl.reg_write = 1'b1;
            ctrl.alu_op    = ALU_OP_RTYPE;
            reads_r1       = 1'b1;
            reads_r2       = 1'b1;
        end else if (instr[31:21] == OP_LDUR) begin
            ctrl.alu_src    = 1'b1;
            ctrl.mem_read   = 1'b1;
            ctrl.mem_to_reg = 1'b1;
            ctrl.reg_write  = 1'b1;
            ctrl.alu_op     = ALU_OP_ADD;
            immediate       = imm_d9;
            reads_r1        = 1'b1;
        end else if (instr[31:21] == OP_STUR) begin
            ctrl.reg2loc   = 1'b1;
            ctrl.alu_src   = 1'b1;
            ctrl.mem_write = 1'b1;
            ctrl.alu_op    = ALU_OP_ADD;
            immediate      = imm_d9;
            reads_r1       = 1'b1;
            reads_r2       = 1'b1;
        end else if (instr[31:24] == OP_CBZ || instr[31:24] == OP_CBNZ) begin
            ctrl.reg2loc   = 1'b1;
            ctrl.branch    = 1'b1;
            ctrl.branch_nz = instr[24];
            ctrl.alu_op    = ALU_OP_CBZ;
            immediate      = imm_cb;
            reads_r2       = 1'b1;
        end else if (instr[31:26] == OP_B || instr[31:26] == OP_BL) begin
            ctrl.uncondbranch = 1'b1;
            immediate         = imm_b;
            uncond            = 1'b1;
            if (instr[31]) begin
                ctrl.reg_write = 1'b1;
                write_register = LINK_REG;
            end
        end else if (instr[31:22] == OP_ADDI) begin
            ctrl.alu_src   = 1'b1;
            ctrl.reg_write = 1'b1;
            ctrl.alu_op    = ALU_OP_ADD;
            immediate      = imm_i12;
            reads_r1       = 1'b1;
        end else if (instr[31:23] == OP_MOVK && (XLEN == 64 || !instr[22])) begin
            ctrl.alu_src   = 1'b1;
            ctrl.reg_write = 1'b1;
            ctrl.alu_op    = ALU_OP_MOV;
            immediate      = imm_mov;
            reads_r1       = 1'b1;
        end else begin
            illegal = 1'b1;
        end
        register1 = uncond ? XZR : instr[9:5];
        register2 = uncond ? XZR : (ctrl.reg2loc ? instr[4:0] : instr[20:16]);
    end

endmodule

// File: rtl/decode_stage.sv
// rtl/decode_stage.sv - registered LEGv8 decode stage; DECODE_HAZARD_EN enables load-use bubbles.
module decode_stage
    import decode_pkg::*;
#(
    parameter int XLEN         = 64,
    parameter int SHIFT_BRANCH = 0
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_instr,
    input  logic [XLEN-1:0] in_pc,
    input  logic            flush,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_pc,
    output logic [4:0]      register1,
    output logic [4:0]      register2,
    output logic [4:0]      write_register,
    output logic [XLEN-1:0] immediate,
    output logic            reg2loc,
    output logic            uncondbranch,
    output logic            branch,
    output logic            branch_nz,
    output logic            mem_read,
    output logic            mem_to_reg,
    output logic            mem_write,
    output logic            alu_src,
    output logic            reg_write,
    output logic [1:0]      alu_op,
    output logic            illegal
);

    ctrl_t           dec_ctrl;
    logic [4:0]      dec_r1;
    logic [4:0]      dec_r2;
    logic [4:0]      dec_wr;
    logic [XLEN-1:0] dec_imm;
    logic            dec_illegal;
    logic            dec_reads_r1;
    logic            dec_reads_r2;

    logic            valid_q;
    logic            valid_d;
    logic [XLEN-1:0] pc_q;
    ctrl_t           ctrl_q;
    logic [4:0]      r1_q;
    logic [4:0]      r2_q;
    logic [4:0]      wr_q;
    logic [XLEN-1:0] imm_q;
    logic            illegal_q;
    logic            hazard;
    logic            accept;

    decode_comb #(
        .XLEN         (XLEN),
        .SHIFT_BRANCH (SHIFT_BRANCH)
    ) u_comb (
        .instr          (in_instr),
        .ctrl           (dec_ctrl),
        .register1      (dec_r1),
        .register2      (dec_r2),
        .write_register (dec_wr),
        .immediate      (dec_imm),
        .illegal        (dec_illegal),
        .reads_r1       (dec_reads_r1),
        .reads_r2       (dec_reads_r2)
    );

`ifdef DECODE_HAZARD_EN
    // The held output bundle doubles as the load-use tracking state.
    assign hazard = valid_q & ctrl_q.mem_read & (wr_q != XZR) &
                    ((dec_reads_r1 & (dec_r1 == wr_q)) | (dec_reads_r2 & (dec_r2 == wr_q)));
`else
    logic unused_reads;
    assign unused_reads = dec_reads_r1 ^ dec_reads_r2;
    assign hazard       = 1'b0;
`endif

    assign in_ready = reset_n & ~flush & (~valid_q | out_ready) & ~hazard;
    assign accept   = in_valid & in_ready;

    always_comb begin
        valid_d = valid_q;
        if (flush) begin
            valid_d = 1'b0;
        end else if (accept) begin
            valid_d = 1'b1;
        end else if (out_ready) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            valid_q   <= 1'b0;
            pc_q      <= '0;
            ctrl_q    <= '0;
            r1_q      <= '0;
            r2_q      <= '0;
            wr_q      <= '0;
            imm_q     <= '0;
            illegal_q <= 1'b0;
        end else begin
            valid_q <= valid_d;
            if (accept) begin
                pc_q      <= in_pc;
                ctrl_q    <= dec_ctrl;
                r1_q      <= dec_r1;
                r2_q      <= dec_r2;
                wr_q      <= dec_wr;
                imm_q     <= dec_imm;
                illegal_q <= dec_illegal;
            end
        end
    end

    assign out_valid      = valid_q;
    assign out_pc         = pc_q;
    assign register1      = r1_q;
    assign register2      = r2_q;
    assign write_register = wr_q;
    assign immediate      = imm_q;
    assign reg2loc        = ctrl_q.reg2loc;
    assign uncondbranch   = ctrl_q.uncondbranch;
    assign branch         = ctrl_q.branch;
    assign branch_nz      = ctrl_q.branch_nz;
    assign mem_read       = ctrl_q.mem_read;
    assign mem_to_reg     = ctrl_q.mem_to_reg;
    assign mem_write      = ctrl_q.mem_write;
    assign alu_src        = ctrl_q.alu_src;
    assign reg_write      = ctrl_q.reg_write;
    assign alu_op         = ctrl_q.alu_op;
    assign illegal        = illegal_q;

endmodule

// File: tb/tb_decode_stage.sv
// tb/tb_decode_stage.sv - self-checking bench for decode_stage against a mnemonic-level reference model.
module tb_decode_stage;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_instr;
    logic [63:0] in_pc;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] out_pc;
    logic [4:0]  register1, register2, write_register;
    logic [63:0] immediate;
    logic        reg2loc, uncondbranch, branch, branch_nz, mem_read, mem_to_reg;
    logic        mem_write, alu_src, reg_write, illegal;
    logic [1:0]  alu_op;

    typedef struct packed {
        logic [63:0] pc;
        logic [4:0]  r1;
        logic [4:0]  r2;
        logic [4:0]  wr;
        logic [63:0] imm;
        logic        reg2loc, ub, br, bnz, mr, m2r, mw, as, rw;
        logic [1:0]  aluop;
        logic        ill;
    } bundle_t;

    bundle_t obs;
    assign obs = {out_pc, register1, register2, write_register, immediate, reg2loc, uncondbranch,
                  branch, branch_nz, mem_read, mem_to_reg, mem_write, alu_src, reg_write, alu_op, illegal};

    int      errors = 0;
    int      checks = 0;
    logic    m_valid;
    bundle_t m_b;
    logic    m_acc;
    logic    last_ov;
    logic [4:0] last_wr;

`ifdef DECODE_HAZARD_EN
    localparam int EXP_GAP = 1;
`else
    localparam int EXP_GAP = 0;
`endif

    always #5 clk = ~clk;

    decode_stage #(.XLEN(64), .SHIFT_BRANCH(0)) dut (
        .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_instr(in_instr), .in_pc(in_pc), .flush(flush), .out_valid(out_valid),
        .out_ready(out_ready), .out_pc(out_pc), .register1(register1), .register2(register2),
        .write_register(write_register), .immediate(immediate), .reg2loc(reg2loc),
        .uncondbranch(uncondbranch), .branch(branch), .branch_nz(branch_nz),
        .mem_read(mem_read), .mem_to_reg(mem_to_reg), .mem_write(mem_write),
        .alu_src(alu_src), .reg_write(reg_write), .alu_op(alu_op), .illegal(illegal)
    );

    task automatic chk(input string tag, input logic [255:0] o, input logic [255:0] e);
        checks++;
        if (o !== e) begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, o, e);
        end
    endtask

    function automatic logic [63:0] sx(input longint unsigned v, input int bits);
        longint s;
        s = longint'(v);
        if (v >= (64'd1 << (bits - 1))) s = s - (longint'(1) << bits);
        return s;
    endfunction

    function automatic bundle_t model(input logic [31:0] ins, input logic [63:0] pc,
                                      output logic rd1, output logic rd2);
        bundle_t b;
        longint unsigned u;
        longint unsigned op11;
        u    = {32'b0, ins};
        op11 = u >> 21;
        b    = '0;
        b.pc = pc;
        b.r1 = 5'((u >> 5) & 31);
        b.r2 = 5'((u >> 16) & 31);
        b.wr = 5'(u & 31);
        rd1  = 1'b0;
        rd2  = 1'b0;
        if (op11 == 64'h458 || op11 == 64'h658 || op11 == 64'h450 || op11 == 64'h550) begin
            b.rw = 1'b1; b.aluop = 2'd2; rd1 = 1'b1; rd2 = 1'b1;
        end else if (op11 == 64'h7C2) begin
            b.as = 1'b1; b.mr = 1'b1; b.m2r = 1'b1; b.rw = 1'b1;
            b.imm = sx((u >> 12) & 511, 9); rd1 = 1'b1;
        end else if (op11 == 64'h7C0) begin
            b.reg2loc = 1'b1; b.as = 1'b1; b.mw = 1'b1; b.r2 = b.wr;
            b.imm = sx((u >> 12) & 511, 9); rd1 = 1'b1; rd2 = 1'b1;
        end else if ((u >> 24) == 64'hB4 || (u >> 24) == 64'hB5) begin
            b.reg2loc = 1'b1; b.br = 1'b1; b.bnz = ((u >> 24) == 64'hB5); b.aluop = 2'd1;
            b.r2 = b.wr; b.imm = sx((u >> 5) & 64'h7FFFF, 19); rd2 = 1'b1;
        end else if ((u >> 26) == 64'd5 || (u >> 26) == 64'd37) begin
            b.ub = 1'b1; b.imm = sx(u & 64'h3FFFFFF, 26); b.r1 = 5'd31; b.r2 = 5'd31;
            if ((u >> 26) == 64'd37) begin b.rw = 1'b1; b.wr = 5'd30; end
        end else if ((u >> 22) == 64'h244) begin
            b.as = 1'b1; b.rw = 1'b1; b.imm = sx((u >> 10) & 4095, 12); rd1 = 1'b1;
        end else if ((u >> 23) == 64'h1E5) begin
            b.as = 1'b1; b.rw = 1'b1; b.aluop = 2'd3; rd1 = 1'b1;
            b.imm = ((u >> 5) & 65535) << (16 * ((u >> 21) & 3));
        end else begin
            b.ill = 1'b1;
        end
        return b;
    endfunction

    function automatic logic [31:0] rand_instr();
        logic [31:0] r;
        r = $urandom;
        case ($urandom_range(0, 9))
            0: case ($urandom_range(0, 3))
                   0: r[31:21] = 11'h458;
                   1: r[31:21] = 11'h658;
                   2: r[31:21] = 11'h450;
                   default: r[31:21] = 11'h550;
               endcase
            1, 7: r[31:21] = 11'h7C2;
            2: r[31:21] = 11'h7C0;
            3: r[31:25] = 7'b1011010;
            4: r[30:26] = 5'b00101;
            5: r[31:22] = 10'h244;
            6: r[31:23] = 9'h1E5;
            default: ;
        endcase
        if ($urandom_range(0, 1) == 1) begin
            r[9:5]   = 5'($urandom_range(0, 3));
            r[4:0]   = 5'($urandom_range(0, 3));
            r[20:16] = 5'($urandom_range(0, 3));
        end
        return r;
    endfunction

    task automatic step(input logic v, input logic [31:0] ins, input logic [63:0] pc,
                        input logic fl, input logic ordy);
        bundle_t e;
        logic rd1, rd2, haz, rdy;
        in_valid = v; in_instr = ins; in_pc = pc; flush = fl; out_ready = ordy;
        #1;
        e   = model(ins, pc, rd1, rd2);
        haz = 1'b0;
`ifdef DECODE_HAZARD_EN
        haz = m_valid && m_b.mr && (m_b.wr != 5'd31) &&
              ((rd1 && e.r1 == m_b.wr) || (rd2 && e.r2 == m_b.wr));
`endif
        rdy = !fl && (!m_valid || ordy) && !haz;
        chk("in_ready", in_ready, rdy);
        chk("out_valid", out_valid, m_valid);
        if (m_valid) chk("bundle", obs, m_b);
        last_ov = out_valid;
        last_wr = write_register;
        @(posedge clk);
        m_acc = 1'b0;
        if (fl) m_valid = 1'b0;
        else if (v && rdy) begin m_valid = 1'b1; m_b = e; m_acc = 1'b1; end
        else if (ordy) m_valid = 1'b0;
        #1;
    endtask

    task automatic present(input logic [31:0] ins);
        step(1'b1, ins, {32'h0, ins ^ 32'h1000}, 1'b0, 1'b1);
    endtask

    task automatic do_reset(input logic [31:0] ins);
        reset_n = 1'b0; in_valid = 1'b1; in_instr = ins; flush = 1'b0; out_ready = 1'b1;
        #1;
        chk("ready_in_reset", in_ready, 1'b0);
        @(posedge clk);
        #1;
        chk("reset_valid", out_valid, 1'b0);
        chk("reset_imm", immediate, 64'h0);
        chk("reset_bundle", obs, bundle_t'(0));
        m_valid = 1'b0;
        m_b     = '0;
        reset_n = 1'b1;
    endtask

    initial begin
        bundle_t snap;
        int      gap;
        logic    seen, added;
        reset_n = 1'b0; in_valid = 1'b0; in_instr = '0; in_pc = '0; flush = 1'b0; out_ready = 1'b0;
        m_valid = 1'b0; m_b = '0; m_acc = 1'b0; last_ov = 1'b0; last_wr = '0;
        @(posedge clk);
        #1;
        do_reset(32'h8B020001);

        present(32'h17FFFFFF);
        chk("b_imm", immediate, 64'hFFFFFFFFFFFFFFFF);
        chk("b_uncond", uncondbranch, 1'b1);
        chk("b_regwrite", reg_write, 1'b0);
        present(32'h94202002);
        chk("bl_imm", immediate, 64'd2105346);
        chk("bl_regwrite", reg_write, 1'b1);
        chk("bl_wr", write_register, 5'd30);
        present(32'hB42D3945);
        chk("cbz_r2", register2, 5'd5);
        chk("cbz_imm", immediate, 64'd92618);
        chk("cbz_branch", {branch, branch_nz, alu_op}, 4'b1001);
        present(32'hB5D2C6C3);
        chk("cbnz_r2", register2, 5'd3);
        chk("cbnz_imm", immediate, 64'hFFFFFFFFFFFE9636);
        chk("cbnz_nz", branch_nz, 1'b1);
        present(32'h913E03E0);
        chk("addi_fields", {register1, write_register}, 10'b11111_00000);
        chk("addi_imm", immediate, 64'hFFFFFFFFFFFFFF80);
        present(32'hF28000E2);
        chk("movk_wr", write_register, 5'd2);
        chk("movk_imm", immediate, 64'd7);
        chk("movk_aluop", alu_op, 2'b11);
        present(32'h00000000);
        chk("zero_illegal", illegal, 1'b1);
        chk("zero_valid", out_valid, 1'b1);

        present(32'h8A040041);
        snap = m_b;
        for (int k = 0; k < 3; k++) begin
            step(1'b1, 32'h8B020001, 64'h2000, 1'b0, 1'b0);
            chk("hold_stable", obs, snap);
            chk("hold_ready", in_ready, 1'b0);
        end
        step(1'b1, 32'h8B020001, 64'h2000, 1'b0, 1'b1);
        chk("release_valid", out_valid, 1'b1);
        chk("release_wr", write_register, 5'd1);

        step(1'b1, 32'h913E03E0, 64'h3000, 1'b1, 1'b0);
        chk("flush_valid", out_valid, 1'b0);
        step(1'b0, 32'h0, 64'h0, 1'b0, 1'b1);
        chk("flush_not_taken", out_valid, 1'b0);

        step(1'b0, 32'h0, 64'h0, 1'b0, 1'b1);
        step(1'b1, 32'hF8462060, 64'h4000, 1'b0, 1'b1);
        gap = 0; seen = 1'b0; added = 1'b0;
        for (int k = 0; k < 8 && !seen; k++) begin
            step(!added, 32'h8B020001, 64'h4004, 1'b0, 1'b1);
            if (m_acc) added = 1'b1;
            if (last_ov && last_wr == 5'd1) seen = 1'b1;
            else if (!last_ov) gap++;
        end
        chk("hazard_seen", seen, 1'b1);
        chk("hazard_gap", gap, EXP_GAP);

        for (int i = 0; i < 400; i++) begin
            step($urandom_range(0, 9) < 7, rand_instr(), {$urandom, $urandom},
                 $urandom_range(0, 19) == 0, $urandom_range(0, 9) < 7);
        end

        present(32'h8B020001);
        do_reset(32'h913E03E0);
        step(1'b0, 32'h0, 64'h0, 1'b0, 1'b1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
